// File: rtl/obz_bank_ctl.sv
// Output bank controller: registered data and mask feeding a tristate pad bank,
// gated by a dead-time FSM on turn-on and released at once by TSALL or reset.
module obz_bank_ctl #(
    parameter int    WIDTH       = 8,
    parameter int    DEAD_CYCLES = 2,
    parameter string PULL_MODE   = "UP"
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             TSALL,
    input  logic [WIDTH-1:0] D,
    input  logic             LOAD,
    input  logic             T_REQ,
    input  logic [WIDTH-1:0] TMASK,
    output tri   [WIDTH-1:0] O,
    output logic             DRIVING,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        IDLE_Z  = 2'd0,
        WAIT_ON = 2'd1,
        DRIVE   = 2'd2
    } state_t;

    localparam logic [2:0] DEAD_LOAD = 3'((DEAD_CYCLES > 0) ? (DEAD_CYCLES - 1) : 0);

    state_t           state;
    logic [2:0]       dead_cnt;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] pad_oe;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            data_reg <= '0;
            mask_reg <= '1;
        end else begin
            if (LOAD) data_reg <= D;
            mask_reg <= TMASK;
        end
    end

    // DRIVING/BUSY are registered together with the state so they always match it.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state    <= IDLE_Z;
            dead_cnt <= '0;
            DRIVING  <= 1'b0;
            BUSY     <= 1'b0;
        end else if (TSALL) begin
            state    <= IDLE_Z;
            dead_cnt <= '0;
            DRIVING  <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            case (state)
                IDLE_Z: begin
                    if (!T_REQ) begin
                        if (DEAD_CYCLES == 0) begin
                            state   <= DRIVE;
                            DRIVING <= 1'b1;
                        end else begin
                            state    <= WAIT_ON;
                            dead_cnt <= DEAD_LOAD;
                            BUSY     <= 1'b1;
                        end
                    end
                end
                WAIT_ON: begin
                    if (T_REQ) begin
                        state    <= IDLE_Z;
                        dead_cnt <= '0;
                        BUSY     <= 1'b0;
                    end else if (dead_cnt == 3'd0) begin
                        state   <= DRIVE;
                        BUSY    <= 1'b0;
                        DRIVING <= 1'b1;
                    end else begin
                        dead_cnt <= dead_cnt - 3'd1;
                    end
                end
                DRIVE: begin
                    if (T_REQ) begin
                        state   <= IDLE_Z;
                        DRIVING <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE_Z;
                    dead_cnt <= '0;
                    DRIVING  <= 1'b0;
                    BUSY     <= 1'b0;
                end
            endcase
        end
    end

    // TSALL and RSTN gate the pads combinationally so release never waits for CLK.
    assign pad_oe = {WIDTH{(state == DRIVE) && !TSALL && RSTN}} & ~mask_reg;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign O[i] = pad_oe[i] ? data_reg[i] : 1'bz;
        if (PULL_MODE == "UP") begin : g_up
            pullup pu (O[i]);
        end else if (PULL_MODE == "DOWN") begin : g_dn
            pulldown pd (O[i]);
        end
    end

endmodule
